// File: rtl/ble_phy_seq_ctrl_if.sv
// Bus-side signals between the BLE PHY AHB slave (master modport) and the
// sequencer control block (slave modport).
interface ble_phy_seq_ctrl_if;
    logic [11:0] address;
    logic        renable;
    logic        wenable;
    logic [1:0]  data_trans;
    logic [31:0] hwdata_ahb;
    logic [31:0] hrdata_ahb;
    logic        HREADY;
    logic [7:0]  fifo_rd_pntr;
    logic        fifo_empty;
    logic        w_done_flag;
    logic        mode;

    modport master (
        output address, renable, wenable, data_trans, hwdata_ahb,
        input  hrdata_ahb, HREADY, fifo_rd_pntr, fifo_empty, w_done_flag, mode
    );

    modport slave (
        input  address, renable, wenable, data_trans, hwdata_ahb,
        output hrdata_ahb, HREADY, fifo_rd_pntr, fifo_empty, w_done_flag, mode
    );
endinterface

// File: rtl/ble_phy_seq_ctrl.sv
// BLE PHY sequencer: register file, TX/RX FIFOs and burst FSM behind the AHB slave.
// Optional IRQ_EN register and irq output enabled by defining BLE_SEQ_IRQ_EN.
module ble_phy_seq_ctrl #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    ble_phy_seq_ctrl_if.slave        bus,
    output logic [31:0]              phy_tx_data,
    output logic                     phy_tx_valid,
    input  logic                     phy_tx_ready,
    input  logic                     phy_tx_busy,
    input  logic [31:0]              phy_rx_data,
    input  logic                     phy_rx_valid,
    output logic                     phy_en,
    output logic                     irq
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CntOne = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StTxRun, StTxDrain, StRxRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [11:0]      addr_q;
    logic             wr_q, vld_q;
    logic [31:0]      hrdata_q, hrdata_d;
    logic             hready_q;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc, len_eff;
    logic [2:0]       status_q, status_d, irq_en_rd;
    logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [31:0]      tx_mem [Depth];
    logic [31:0]      rx_mem [Depth];

    logic addr_vld, rd_req, wr_reg, wr_ctrl, wr_len, wr_status, wr_data, start, abort;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_wr_en, rx_push, rx_pop, rx_bypass, rx_wr_en;

    assign addr_vld  = (bus.renable | bus.wenable) & bus.data_trans[1];
    assign rd_req    = addr_vld & ~bus.wenable;
    assign wr_reg    = vld_q & wr_q & (addr_q[11:4] == '0);
    assign wr_ctrl   = wr_reg & (addr_q[3:2] == 2'd0);
    assign wr_len    = wr_reg & (addr_q[3:2] == 2'd1);
    assign wr_status = wr_reg & (addr_q[3:2] == 2'd2);
    assign wr_data   = vld_q & wr_q & (addr_q[11:4] != '0);
    assign abort     = wr_ctrl & bus.hwdata_ahb[2];
    assign start     = wr_ctrl & bus.hwdata_ahb[1] & ~bus.hwdata_ahb[2];

    // Wrap bit distinguishes full from empty when the index bits match.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                      (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                      (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
    assign len_eff = (len_q == '0) ? CntOne : len_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        len_d        = len_q;
        status_d     = status_q;
        hrdata_d     = '0;
        tx_push      = wr_data;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        rx_pop       = 1'b0;
        rx_bypass    = 1'b0;
        phy_tx_valid = 1'b0;
        phy_en       = 1'b0;

        if (wr_ctrl && state_q == StIdle) mode_d = bus.hwdata_ahb[0];
        if (wr_len) len_d = bus.hwdata_ahb[LEN_W-1:0];
        if (wr_status) status_d = status_q & ~bus.hwdata_ahb[2:0];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = bus.hwdata_ahb[0] ? StTxRun : StRxRun;
                    cnt_d   = '0;
                end
            end
            StTxRun: begin
                phy_en       = 1'b1;
                phy_tx_valid = !tx_empty;
                if (phy_tx_valid && phy_tx_ready) begin
                    tx_pop = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc >= len_eff) state_d = StTxDrain;
                end else if (phy_tx_ready) begin
                    status_d[2] = 1'b1;
                end
            end
            StTxDrain: begin
                phy_en = 1'b1;
                if (!phy_tx_busy) state_d = StDone;
            end
            StRxRun: begin
                phy_en = 1'b1;
                if (phy_rx_valid) begin
                    rx_push = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= len_eff) state_d = StDone;
                end
            end
            StDone: begin
                status_d[0] = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Read data is captured at the address-phase edge; an RX read on an
        // empty FIFO with a word arriving the same cycle passes it straight through.
        if (rd_req) begin
            if (bus.address[11:4] != '0) begin
                if (!rx_empty) begin
                    hrdata_d = rx_mem[rx_rd_q[FIFO_AW-1:0]];
                    rx_pop   = 1'b1;
                end else if (rx_push) begin
                    hrdata_d  = phy_rx_data;
                    rx_bypass = 1'b1;
                end
            end else begin
                unique case (bus.address[3:2])
                    2'd0:    hrdata_d = {31'b0, mode_q};
                    2'd1:    hrdata_d = 32'(len_q);
                    2'd2:    hrdata_d = {29'b0, status_q};
                    default: hrdata_d = {29'b0, irq_en_rd};
                endcase
            end
        end

        tx_wr_en = tx_push && (!tx_full || tx_pop);
        rx_wr_en = rx_push && !rx_bypass && (!rx_full || rx_pop);
        if (rx_push && rx_full && !rx_pop) status_d[1] = 1'b1;

        tx_wr_d = tx_wr_en ? tx_wr_q + PtrOne : tx_wr_q;
        tx_rd_d = tx_pop   ? tx_rd_q + PtrOne : tx_rd_q;
        rx_wr_d = rx_wr_en ? rx_wr_q + PtrOne : rx_wr_q;
        rx_rd_d = rx_pop   ? rx_rd_q + PtrOne : rx_rd_q;

        if (abort) begin
            state_d  = StIdle;
            cnt_d    = '0;
            status_d = status_q;
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            vld_q    <= 1'b0;
            hrdata_q <= '0;
            hready_q <= 1'b1;
            mode_q   <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= bus.address;
            wr_q     <= bus.wenable;
            vld_q    <= addr_vld;
            hrdata_q <= hrdata_d;
            hready_q <= ~abort;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (tx_wr_en) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= bus.hwdata_ahb;
        if (rx_wr_en) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= phy_rx_data;
    end

`ifdef BLE_SEQ_IRQ_EN
    logic [2:0] irq_en_q;
    logic       irq_q;
    logic       wr_irq_en;

    assign wr_irq_en = wr_reg & (addr_q[3:2] == 2'd3);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_irq_en) irq_en_q <= bus.hwdata_ahb[2:0];
            irq_q <= |(status_q & irq_en_q);
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_q;
`else
    assign irq_en_rd = 3'b0;
    assign irq       = 1'b0;
`endif

    assign bus.hrdata_ahb   = hrdata_q;
    assign bus.HREADY       = hready_q;
    assign bus.fifo_rd_pntr = 8'(tx_rd_q[FIFO_AW-1:0]);
    assign bus.fifo_empty   = rx_empty;
    assign bus.w_done_flag  = tx_full;
    assign bus.mode         = mode_q;
    assign phy_tx_data      = tx_mem[tx_rd_q[FIFO_AW-1:0]];

    logic unused_ok;
    assign unused_ok = ^{bus.hwdata_ahb, addr_q[1:0]};
endmodule

// File: doc/ble_phy_seq_ctrl.md
Name: ble_phy_seq_ctrl

Overview:
- Control module behind the BLE PHY AHB slave.
- Decodes the slave's address/renable/wenable strobes into a small register file, a TX FIFO and an RX FIFO.
- Sequences one TX or RX burst of LEN 32-bit words to or from the PHY serializer.
- Drives the slave's hrdata_ahb, HREADY, fifo_empty, fifo_rd_pntr, w_done_flag and mode inputs.

Parameters:
- FIFO_AW, 4: log2 of TX/RX FIFO depth (depth 16 words, max 2^8 since fifo_rd_pntr is 8 bits).
- LEN_W, 8: width of LEN register and word counters.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous active-high reset.
- address  in  12  byte address from slave (address phase).
- renable  in  1  read strobe (address phase).
- wenable  in  1  write strobe (address phase).
- data_trans  in  2  HTRANS from slave; a transfer is valid only if NONSEQ(10) or SEQ(11).
- hwdata_ahb  in  32  write data (data phase).
- hrdata_ahb  out  32  read data (data phase).
- HREADY  out  1  ready to slave.
- fifo_rd_pntr  out  8  TX FIFO read pointer, zero-extended.
- fifo_empty  out  1  RX FIFO empty.
- w_done_flag  out  1  TX FIFO full (slave stalls writes when mode=1).
- mode  out  1  CTRL[0]: 1=TX, 0=RX.
- phy_tx_data  out  32  word to serializer.
- phy_tx_valid  out  1  word valid.
- phy_tx_ready  in  1  serializer accepts word.
- phy_tx_busy  in  1  serializer still shifting bits.
- phy_rx_data  in  32  received word.
- phy_rx_valid  in  1  one-cycle received-word strobe.
- phy_en  out  1  PHY enable (high in TX_RUN/TX_DRAIN/RX_RUN).
- irq  out  1  interrupt (see Optional Feature).

Behaviour:
- Register map:
  - 0x0 CTRL: [0] mode, [1] start (W1, self-clearing), [2] abort (W1, self-clearing).
  - 0x4 LEN: words per burst, LEN_W bits; 0 is treated as 1.
  - 0x8 STATUS: [0] done, [1] rx_overflow, [2] tx_underrun; write-1-to-clear; read-only to the slave in practice.
  - 0xC IRQ_EN (optional).
  - >=0x10 data window: write pushes TX FIFO, read pops RX FIFO.
- Transfer pipeline: valid transfer = (renable|wenable) && data_trans[1]. In the address phase, address, write flag and valid are registered. The write is performed in the following data phase using hwdata_ahb.
- Reads:
  - hrdata_ahb is registered, valid in the data phase (1-cycle latency).
  - An RX pop happens at the address phase edge.
  - Unmapped reads return 0.
- Reset: all registers, pointers, counters and STATUS = 0; state=IDLE. Outputs: hrdata_ahb=0, HREADY=1, fifo_rd_pntr=0, fifo_empty=1, w_done_flag=0, mode=0, phy_tx_valid=0, phy_en=0, irq=0.
- FSM states: IDLE, TX_RUN, TX_DRAIN, RX_RUN, DONE.
  - IDLE: on start with mode=1 -> TX_RUN; on start with mode=0 -> RX_RUN; word counter cleared.
  - TX_RUN: phy_tx_valid = !tx_empty; phy_tx_data = FIFO head; pop on valid&&ready; counter+1. Counter==LEN -> TX_DRAIN. If FIFO is empty while phy_tx_ready=1, set tx_underrun and keep waiting (no abort).
  - TX_DRAIN: wait for phy_tx_busy=0 -> DONE.
  - RX_RUN: on phy_rx_valid, push to RX FIFO and counter+1. If the RX FIFO is full, drop the word, set rx_overflow, and still count it. Counter==LEN -> DONE.
  - DONE: set STATUS.done; next cycle -> IDLE.
- Abort (any state): next state IDLE, both FIFOs flushed (pointers=0), counter=0, phy_tx_valid=0, STATUS unchanged. HREADY=0 for exactly the one cycle after the abort write, then 1. Otherwise HREADY is always 1.
- Simultaneous events:
  - Start while not IDLE is ignored.
  - Start and abort in the same write: abort wins.
  - Push and pop in the same cycle on a full or empty FIFO are both legal; count is unchanged.
  - A TX FIFO write while full is dropped. The slave's w_done_flag stall normally prevents it.
- Mode writes while not IDLE are ignored (mode is frozen during a burst).
- FIFO pointers are FIFO_AW+1 bits with a wrap bit: full = MSBs differ and lower bits are equal.
- Counters saturate at 2^LEN_W-1.

Optional Feature:
- BLE_SEQ_IRQ_EN defined:
  - IRQ_EN register at 0xC, bits [2:0] mask the STATUS bits.
  - irq is registered: irq = |(STATUS & IRQ_EN), asserted the cycle after the STATUS bit sets, low after W1C.
- Undefined: irq tied 0, 0xC reads 0, writes to it are ignored.

Test Plan:
- Write LEN=4, write 4 words 0xA0..0xA3 to 0x10, write CTRL=0x3, phy_tx_ready=1, phy_tx_busy low 5 cycles after the last pop -> phy_tx_data sequence A0..A3, fifo_rd_pntr 0->4, STATUS=0x1.
- Write 17 words to 0x10 with mode=1, no start -> w_done_flag=1 after the 16th; 17th dropped; pointer unchanged.
- Mode=0, LEN=3, start, 3 phy_rx_valid pulses 0xB0..B2 -> fifo_empty=0; reads at 0x10 return B0, B1, B2 in successive data phases; fifo_empty=1; STATUS.done=1.
- RX LEN=20, 20 pulses, no reads -> first 16 stored, rx_overflow=1, DONE after 20th.
- Abort (CTRL=0x4) mid TX_RUN with 8 words queued -> IDLE next cycle, HREADY=0 for one cycle, FIFO empty, phy_en=0.
- BLE_SEQ_IRQ_EN: IRQ_EN=0x1, complete TX -> irq=1 one cycle after done; write STATUS=0x1 -> irq=0.
